// File: rtl/tusca_tx_medida.sv
// tusca_tx_medida -- UART 8N1 transmitter for one measurement frame.
// Frame on the line: HEADER, umidade, temperatura[, checksum], each byte
// sent as start bit, 8 data bits LSB first, stop bit, with no gap between
// the bytes of a frame.
// Optional feature: define TUSCA_TX_CHECKSUM_EN to append the checksum byte
// (umidade + temperatura, mod 256). Without it the frame is three bytes.
module tusca_tx_medida #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       medir,
  input  logic [7:0] umidade,
  input  logic [7:0] temperatura,
  output logic       tx_serial,
  output logic       ocupado,
  output logic       pronto,
  output logic       descartado
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 32'd1);
`ifdef TUSCA_TX_CHECKSUM_EN
  localparam logic [1:0]  BYTE_LAST = 2'd3;
`else
  localparam logic [1:0]  BYTE_LAST = 2'd2;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [15:0] baud_q, baud_d;
  logic [7:0]  umid_q, umid_d;
  logic [7:0]  temp_q, temp_d;
  logic        tx_q, tx_d;
  logic        ocup_q, ocup_d;
  logic        pronto_q, pronto_d;
  logic        desc_q, desc_d;

  logic [7:0]  cur_byte;
  logic [2:0]  bit_idx_nx;
  logic        bit_end;

  assign bit_end    = (baud_q == BAUD_LAST);
  assign bit_idx_nx = bit_idx_q + 3'd1;

`ifdef TUSCA_TX_CHECKSUM_EN
  logic [7:0] checksum;
  // Checksum is taken from the latched bytes so input changes mid-frame are invisible
  assign checksum = umid_q + temp_q;
`endif

  // Select the byte currently on the line
  always_comb begin
    cur_byte = HEADER;
    case (byte_idx_q)
      2'd0:    cur_byte = HEADER;
      2'd1:    cur_byte = umid_q;
      2'd2:    cur_byte = temp_q;
`ifdef TUSCA_TX_CHECKSUM_EN
      default: cur_byte = checksum;
`else
      default: cur_byte = '0;
`endif
    endcase
  end

  // Next-state logic: bit timing, bit/byte sequencing and registered line value
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    baud_d     = baud_q;
    umid_d     = umid_q;
    temp_d     = temp_q;
    tx_d       = tx_q;
    pronto_d   = 1'b0;
    // A request seen while busy is dropped and only reported
    desc_d     = medir & ocup_q;

    if (state_q == IDLE) begin
      tx_d       = 1'b1;
      baud_d     = '0;
      bit_idx_d  = '0;
      byte_idx_d = '0;
      if (medir) begin
        umid_d  = umidade;
        temp_d  = temperatura;
        state_d = START;
        tx_d    = 1'b0;
      end
    end else if (!bit_end) begin
      baud_d = baud_q + 16'd1;
    end else begin
      baud_d = '0;
      case (state_q)
        START: begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = cur_byte[0];
        end
        DATA: begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_nx;
            tx_d      = cur_byte[bit_idx_nx];
          end
        end
        STOP: begin
          if (byte_idx_q == BYTE_LAST) begin
            state_d    = IDLE;
            byte_idx_d = '0;
            tx_d       = 1'b1;
            pronto_d   = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = START;
            tx_d       = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end

    ocup_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      baud_q     <= '0;
      umid_q     <= '0;
      temp_q     <= '0;
      tx_q       <= 1'b1;
      ocup_q     <= 1'b0;
      pronto_q   <= 1'b0;
      desc_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      baud_q     <= baud_d;
      umid_q     <= umid_d;
      temp_q     <= temp_d;
      tx_q       <= tx_d;
      ocup_q     <= ocup_d;
      pronto_q   <= pronto_d;
      desc_q     <= desc_d;
    end
  end

  assign tx_serial  = tx_q;
  assign ocupado    = ocup_q;
  assign pronto     = pronto_q;
  assign descartado = desc_q;

endmodule

// File: tb/tb_tusca_tx_medida.sv
// Testbench for tusca_tx_medida with CLKS_PER_BIT=4.
// Frame length follows TUSCA_TX_CHECKSUM_EN (4 bytes if defined, else 3).
`timescale 1ns/1ps
module tb_tusca_tx_medida;

  localparam int C = 4;
  localparam logic [7:0] HDR = 8'hA5;
`ifdef TUSCA_TX_CHECKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif
  localparam int FRAME = NB * 10 * C;

  logic       clock = 1'b0;
  logic       reset;
  logic       medir;
  logic [7:0] umidade;
  logic [7:0] temperatura;
  logic       tx_serial;
  logic       ocupado;
  logic       pronto;
  logic       descartado;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  tusca_tx_medida #(.CLKS_PER_BIT(C), .HEADER(HDR)) dut (
    .clock       (clock),
    .reset       (reset),
    .medir       (medir),
    .umidade     (umidade),
    .temperatura (temperatura),
    .tx_serial   (tx_serial),
    .ocupado     (ocupado),
    .pronto      (pronto),
    .descartado  (descartado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive a one-cycle request at the current negedge and queue the expected frame.
  task automatic request(input logic [7:0] u, input logic [7:0] t, output int t_req);
    logic [7:0] s;
    umidade = u; temperatura = t; medir = 1'b1;
    t_req = cyc;
    s = u + t;
    exp_q.push_back(HDR);
    exp_q.push_back(u);
    exp_q.push_back(t);
    if (NB == 4) exp_q.push_back(s);
    @(negedge clock);
    medir = 1'b0;
    umidade = 8'($urandom);
    temperatura = 8'($urandom);
  endtask

  // Capture one frame from the line; returns at the negedge after the last bit cell.
  task automatic rx_frame(output logic [31:0] rb, output int t_low, output int ferr,
                          output int busy_err, output int n_desc, output logic pr_early,
                          output logic pr_end, output logic oc_end, output logic tx_end);
    int w, j, pos, bt;
    logic lvl;
    rb = '0; t_low = -1; ferr = 0; busy_err = 0; n_desc = 0; pr_early = 1'b0;
    pr_end = 1'b0; oc_end = 1'b1; tx_end = 1'b0; lvl = 1'b1;
    w = 0;
    while (tx_serial !== 1'b0 && w < 50) begin
      @(negedge clock);
      w++;
    end
    if (tx_serial !== 1'b0) return;
    t_low = cyc;
    for (int s = 0; s < FRAME; s++) begin
      if (s > 0) @(negedge clock);
      if (s % C == 0) begin
        lvl = tx_serial;
        j = s / C; pos = j % 10; bt = j / 10;
        if (pos == 0 && lvl !== 1'b0) ferr++;
        else if (pos == 9 && lvl !== 1'b1) ferr++;
        else if (pos >= 1 && pos <= 8) rb[8*bt + pos - 1] = lvl;
      end else if (tx_serial !== lvl) ferr++;
      if (ocupado !== 1'b1) busy_err++;
      if (pronto !== 1'b0) pr_early = 1'b1;
      if (descartado === 1'b1) n_desc++;
    end
    @(negedge clock);
    pr_end = pronto; oc_end = ocupado; tx_end = tx_serial;
    if (descartado === 1'b1) n_desc++;
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1; medir = 1'b1; umidade = 8'h11; temperatura = 8'h22;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (tx_serial !== 1'b1 || ocupado !== 1'b0 || pronto !== 1'b0 || descartado !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got tx=%b ocup=%b pronto=%b desc=%b expected 1 0 0 0",
               tx_serial, ocupado, pronto, descartado);
    end
    reset = 1'b0; medir = 1'b0;
    bad = 0;
    repeat (8) begin
      @(negedge clock);
      if (tx_serial !== 1'b1 || ocupado !== 1'b0 || descartado !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL reset_medir_ignored: got %0d busy/low cycles expected 0", bad);
    end
  endtask

  task automatic test_basic();
    int tr, tl, fe, be, nd;
    logic [31:0] rb;
    logic pe, pr, oc, tx;
    logic [7:0] e;
    request(8'h3C, 8'h19, tr);
    rx_frame(rb, tl, fe, be, nd, pe, pr, oc, tx);
    n_cmp++;
    if (tl !== tr + 1) begin
      n_bad++; $display("FAIL basic_latency: got %0d expected %0d", tl, tr + 1);
    end
    for (int k = 0; k < NB; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rb[8*k +: 8] !== e) begin
        n_bad++; $display("FAIL basic_byte%0d: got %h expected %h", k, rb[8*k +: 8], e);
      end
    end
    n_cmp++;
    if (fe != 0 || be != 0) begin
      n_bad++; $display("FAIL basic_framing: got ferr=%0d busy_err=%0d expected 0 0", fe, be);
    end
    n_cmp++;
    if (pr !== 1'b1 || oc !== 1'b0 || tx !== 1'b1 || pe !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_pronto: got pronto=%b ocup=%b tx=%b early=%b expected 1 0 1 0",
               pr, oc, tx, pe);
    end
    @(negedge clock);
    n_cmp++;
    if (pronto !== 1'b0 || nd != 0) begin
      n_bad++; $display("FAIL basic_pulse: got pronto=%b desc=%0d expected 0 0", pronto, nd);
    end
  endtask

  task automatic test_wrap();
    int tr, tl, fe, be, nd;
    logic [31:0] rb;
    logic pe, pr, oc, tx;
    logic [7:0] e;
    repeat (2) @(negedge clock);
    request(8'hF0, 8'h20, tr);
    rx_frame(rb, tl, fe, be, nd, pe, pr, oc, tx);
    for (int k = 0; k < NB; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rb[8*k +: 8] !== e) begin
        n_bad++; $display("FAIL wrap_byte%0d: got %h expected %h", k, rb[8*k +: 8], e);
      end
    end
`ifdef TUSCA_TX_CHECKSUM_EN
    n_cmp++;
    if (rb[31:24] !== 8'h10) begin
      n_bad++; $display("FAIL wrap_checksum: got %h expected 10", rb[31:24]);
    end
`endif
    n_cmp++;
    if (fe != 0 || pr !== 1'b1) begin
      n_bad++; $display("FAIL wrap_frame: got ferr=%0d pronto=%b expected 0 1", fe, pr);
    end
  endtask

  task automatic test_discard();
    int tr, tl, fe, be, nd, bad;
    logic [31:0] rb;
    logic pe, pr, oc, tx;
    logic [7:0] e;
    repeat (2) @(negedge clock);
    request(8'h5A, 8'hC3, tr);
    fork
      rx_frame(rb, tl, fe, be, nd, pe, pr, oc, tx);
      begin
        repeat (30) @(negedge clock);
        medir = 1'b1; umidade = 8'hEE; temperatura = 8'hDD;
        repeat (3) @(negedge clock);
        medir = 1'b0;
      end
    join
    n_cmp++;
    if (nd != 3) begin
      n_bad++; $display("FAIL discard_pulses: got %0d expected 3", nd);
    end
    n_cmp++;
    if (tl !== tr + 1 || fe != 0 || pr !== 1'b1) begin
      n_bad++;
      $display("FAIL discard_timing: got low=%0d ferr=%0d pronto=%b expected %0d 0 1",
               tl, fe, pr, tr + 1);
    end
    for (int k = 0; k < NB; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rb[8*k +: 8] !== e) begin
        n_bad++; $display("FAIL discard_byte%0d: got %h expected %h", k, rb[8*k +: 8], e);
      end
    end
    bad = 0;
    repeat (10) begin
      @(negedge clock);
      if (tx_serial !== 1'b1 || ocupado !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL discard_no_queue: got %0d busy cycles expected 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int tr, tl, fe, be, nd;
    logic [31:0] rb;
    logic pe, pr, oc, tx;
    logic [7:0] e;
    request(8'h77, 8'h88, tr);
    repeat (22 * C + 1) @(negedge clock);
    n_cmp++;
    if (ocupado !== 1'b1) begin
      n_bad++; $display("FAIL midreset_busy: got ocup=%b expected 1", ocupado);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    n_cmp++;
    if (tx_serial !== 1'b1 || ocupado !== 1'b0 || pronto !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got tx=%b ocup=%b pronto=%b expected 1 0 0",
               tx_serial, ocupado, pronto);
    end
    repeat (3) @(negedge clock);
    request(8'h01, 8'hFE, tr);
    rx_frame(rb, tl, fe, be, nd, pe, pr, oc, tx);
    for (int k = 0; k < NB; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rb[8*k +: 8] !== e) begin
        n_bad++; $display("FAIL midreset_byte%0d: got %h expected %h", k, rb[8*k +: 8], e);
      end
    end
    n_cmp++;
    if (tl !== tr + 1 || fe != 0 || pr !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_frame: got low=%0d ferr=%0d pronto=%b expected %0d 0 1",
               tl, fe, pr, tr + 1);
    end
  endtask

  task automatic test_back_to_back();
    int tr1, tl1, tr2, tl2, fe, be, nd;
    logic [31:0] rb1, rb2;
    logic pe, pr, oc, tx;
    logic [7:0] e;
    repeat (2) @(negedge clock);
    request(8'h3C, 8'h19, tr1);
    rx_frame(rb1, tl1, fe, be, nd, pe, pr, oc, tx);
    n_cmp++;
    if (pr !== 1'b1) begin
      n_bad++; $display("FAIL b2b_first_pronto: got %b expected 1", pr);
    end
    request(8'hAB, 8'hCD, tr2);
    rx_frame(rb2, tl2, fe, be, nd, pe, pr, oc, tx);
    n_cmp++;
    if (tl2 !== tl1 + FRAME + 1 || tl2 !== tr2 + 1) begin
      n_bad++; $display("FAIL b2b_gap: got low=%0d expected %0d", tl2, tl1 + FRAME + 1);
    end
    for (int k = 0; k < NB; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rb1[8*k +: 8] !== e) begin
        n_bad++; $display("FAIL b2b_f1_byte%0d: got %h expected %h", k, rb1[8*k +: 8], e);
      end
    end
    for (int k = 0; k < NB; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rb2[8*k +: 8] !== e) begin
        n_bad++; $display("FAIL b2b_f2_byte%0d: got %h expected %h", k, rb2[8*k +: 8], e);
      end
    end
    n_cmp++;
    if (fe != 0 || pr !== 1'b1 || nd != 0) begin
      n_bad++;
      $display("FAIL b2b_second: got ferr=%0d pronto=%b desc=%0d expected 0 1 0", fe, pr, nd);
    end
  endtask

  initial begin
    reset = 1'b1; medir = 1'b0; umidade = '0; temperatura = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_discard();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
